// File: rtl/tile_sequencer.sv
// Loop-nest controller: walks (i,j,k) tile triples i-outer/k-inner, one command per handshake.
// Latency: first command valid 1 cycle after start; one command per cycle while tile_ready is high.
// Backpressure: command fields hold stable while tile_valid & !tile_ready; abort cancels the job.
module tile_sequencer #(
    parameter int TILES_M = 3,
    parameter int TILES_N = 3,
    parameter int TILES_K = 3,
    localparam int IW = $clog2(TILES_M + 1),
    localparam int JW = $clog2(TILES_N + 1),
    localparam int KW = $clog2(TILES_K + 1),
    localparam int CW = $clog2(TILES_M * TILES_N * TILES_K + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          tile_valid,
    input  logic          tile_ready,
    output logic [IW-1:0] tile_i,
    output logic [JW-1:0] tile_j,
    output logic [KW-1:0] tile_k,
    output logic          acc_clear,
    output logic          acc_last,
    output logic [CW-1:0] job_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FIN   = 2'd2
    } state_t;

    localparam logic [IW-1:0] I_MAX = IW'(TILES_M - 1);
    localparam logic [JW-1:0] J_MAX = JW'(TILES_N - 1);
    localparam logic [KW-1:0] K_MAX = KW'(TILES_K - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   i_d;
    logic [JW-1:0]   j_d;
    logic [KW-1:0]   k_d;
    logic [CW-1:0]   count_d;
    logic            hs;

    assign hs = tile_valid & tile_ready;

    // Accumulator control is a pure decode of the registered k index, so it
    // can never disagree with the command it travels with.
    assign acc_clear = (tile_k == '0);
    assign acc_last  = (tile_k == K_MAX);

    // Next-state, index advance and job counter.
    always_comb begin
        state_d = state_q;
        i_d     = tile_i;
        j_d     = tile_j;
        k_d     = tile_k;
        count_d = job_count;
        case (state_q)
            IDLE: begin
                // abort beats start when both arrive together
                if (start && !abort) begin
                    state_d = ISSUE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    count_d = '0;
                end
            end
            ISSUE: begin
                // a handshake in the abort cycle was really taken downstream
                if (hs) begin
                    count_d = job_count + 1'b1;
                end
                if (abort) begin
                    state_d = IDLE;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end else if (hs) begin
                    if (tile_k == K_MAX) begin
                        k_d = '0;
                        if (tile_j == J_MAX) begin
                            j_d = '0;
                            if (tile_i == I_MAX) begin
                                i_d     = '0;
                                state_d = FIN;
                            end else begin
                                i_d = tile_i + 1'b1;
                            end
                        end else begin
                            j_d = tile_j + 1'b1;
                        end
                    end else begin
                        k_d = tile_k + 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, indices, counter and status flags all come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tile_i     <= '0;
            tile_j     <= '0;
            tile_k     <= '0;
            job_count  <= '0;
            tile_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tile_i     <= i_d;
            tile_j     <= j_d;
            tile_k     <= k_d;
            job_count  <= count_d;
            tile_valid <= (state_d == ISSUE);
            busy       <= (state_d == ISSUE);
            done       <= (state_d == FIN);
        end
    end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
Loop-nest controller for the blocked matrix multiplier. On a start pulse it walks every (i, j, k) tile triple in i-outer, j-middle, k-inner order and issues one tile command per triple over a valid/ready stream to the downstream operand-fetch/MAC stage. It also supplies per-command accumulator control: clear on the first k, write-back on the last k. It signals busy/done so the top-level controller can sequence whole matrix jobs.

Parameters:
TILES_M  3  number of row blocks (i range 0..TILES_M-1), must be >= 1
TILES_N  3  number of column blocks (j range 0..TILES_N-1), must be >= 1
TILES_K  3  number of inner-dimension blocks (k range 0..TILES_K-1), must be >= 1

Ports:
clk         input   1                          clock, rising edge
rst         input   1                          asynchronous, active-high reset
start       input   1                          begin a job; sampled only in IDLE
abort       input   1                          synchronous job cancel
busy        output  1                          job in progress (ISSUE state)
done        output  1                          one-cycle pulse, job completed normally
tile_valid  output  1                          tile command valid
tile_ready  input   1                          downstream accepts command
tile_i      output  $clog2(TILES_M+1)          row block index
tile_j      output  $clog2(TILES_N+1)          column block index
tile_k      output  $clog2(TILES_K+1)          inner block index
acc_clear   output  1                          command is first k (k==0): clear accumulator before MAC
acc_last    output  1                          command is last k (k==TILES_K-1): write back after MAC
job_count   output  $clog2(TILES_M*TILES_N*TILES_K+1)  commands accepted in current/last job

Behaviour:
- All outputs registered. Reset (rst=1, asynchronous) forces: state=IDLE; busy=0; done=0; tile_valid=0; tile_i=tile_j=tile_k=0; job_count=0. acc_clear=1 and acc_last=(TILES_K==1), as combinational decodes of tile_k=0.
- States: IDLE, ISSUE, FIN.
- IDLE: tile_valid=0, busy=0. If start=1 then next cycle: ISSUE, indices=0, job_count=0, tile_valid=1, busy=1. Start-to-first-valid latency is 1 cycle.
- ISSUE: tile_valid=1. Handshake = tile_valid & tile_ready.
  - Without a handshake, tile_i/j/k, acc_clear and acc_last hold stable.
  - On a handshake, job_count increments and the indices advance:
    - k==TILES_K-1: k wraps to 0 and j advances.
    - j==TILES_N-1 on that wrap: j wraps to 0 and i increments.
  - On a handshake with i, j, k all at maximum (final command): next cycle is FIN, tile_valid=0, busy=0, indices return to 0.
- Back-to-back handshakes (tile_ready held high) issue one command per cycle. Total commands per job = TILES_M*TILES_N*TILES_K.
- FIN: done=1 for exactly one cycle, then IDLE. job_count holds its final value until the next start.
- start while busy or in FIN: ignored; no restart, no queueing.
- abort=1 in ISSUE: next cycle IDLE, tile_valid=0, busy=0, indices=0, no done pulse. A handshake coinciding with abort still counts in job_count. abort has priority over the FIN transition. abort in IDLE/FIN: no effect; start and abort together in IDLE: abort wins, stay IDLE.
- Degenerate TILES_*=1: the corresponding index is always 0. With all three =1 there is a single command carrying acc_clear=1 and acc_last=1.
- Reset mid-job: immediate return to the reset values; no done pulse; the downstream drops any partially consumed command.

Test Plan:
1. Defaults, tile_ready=1, start pulse -> valid 1 cycle later; 27 commands on consecutive cycles, (i,j,k) order (0,0,0),(0,0,1),(0,0,2),(0,1,0)...(2,2,2). acc_clear on k=0, acc_last on k=2. done pulses 1 cycle after the 27th handshake; job_count=27.
2. tile_ready toggled pseudo-randomly -> indices and flags stable while stalled; no command skipped or duplicated; still 27 commands, done once.
3. Start asserted during ISSUE and during FIN -> no effect; second start in IDLE runs a fresh 27-command job from (0,0,0).
4. abort after 10 handshakes, with tile_ready=1 on the abort cycle -> job_count=11, IDLE next cycle, no done. Following start runs a full job.
5. rst asserted asynchronously mid-job (between clock edges) -> outputs zero immediately without waiting for clk; done never pulses.
6. TILES_M=1, TILES_N=2, TILES_K=1 -> exactly 2 commands (0,0,0),(0,1,0), each with acc_clear=acc_last=1; then done.
